// File: rtl/riv_sync_fifo_pkg.sv
// riv_sync_fifo_pkg: sizing helpers and elaboration-time parameter checks shared by riv_sync_fifo.
// RIV_FIFO_CHECK(label, cond) stops elaboration when a parameter is out of range.
package riv_sync_fifo_pkg;
    function automatic int riv_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    // riv_fifo_ptr_t width rule: max(1, clog2(DEPTH)), so DEPTH=2 still gets a 1-bit pointer
    function automatic int riv_ptr_w(input int depth);
        return riv_clog2(depth) > 1 ? riv_clog2(depth) : 1;
    endfunction
endpackage

`ifndef RIV_FIFO_CHECK
`define RIV_FIFO_CHECK(lbl, cond) if (!(cond)) begin : lbl $error("riv_sync_fifo: parameter check failed"); end
`endif

// File: rtl/riv_sync_fifo_ram.sv
// riv_sync_fifo_ram: DEPTH x W storage, one synchronous write port and one combinational read port.
module riv_sync_fifo_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_wen) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/riv_sync_fifo.sv
// riv_sync_fifo: single-clock FWFT FIFO with fill level, almost-full/empty flags and flush.
// Define RIV_SYNC_FIFO_PARITY_EN to store an even-parity bit per word and pulse parity_err on a bad pop.
module riv_sync_fifo
    import riv_sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int AF_LEVEL   = 12,
    parameter  int AE_LEVEL   = 2,
    localparam int CNT_W      = riv_clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef RIV_SYNC_FIFO_PARITY_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int PTR_W = riv_ptr_w(DEPTH);
`ifdef RIV_SYNC_FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef logic [PTR_W-1:0] riv_fifo_ptr_t;

    localparam riv_fifo_ptr_t    LAST_P = PTR_W'(DEPTH - 1);
    localparam riv_fifo_ptr_t    ONE_P  = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

    `RIV_FIFO_CHECK(g_chk_dw, DATA_WIDTH >= 1)
    `RIV_FIFO_CHECK(g_chk_depth, DEPTH >= 2)
    `RIV_FIFO_CHECK(g_chk_af, AF_LEVEL >= 1 && AF_LEVEL <= DEPTH)
    `RIV_FIFO_CHECK(g_chk_ae, AE_LEVEL >= 0 && AE_LEVEL < DEPTH)

    riv_fifo_ptr_t    r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;
    logic [MEM_W-1:0] w_wdata, w_rdata;

    // handshakes see only registered count, so s_ready/m_valid never depend on s_valid/m_ready
    assign s_ready      = r_count != FULL_C;
    assign m_valid      = r_count != '0;
    assign count        = r_count;
    assign almost_full  = r_count >= AF_C;
    assign almost_empty = r_count <= AE_C;
    assign w_push       = s_valid & s_ready;
    assign w_pop        = m_valid & m_ready;
    assign w_wptr_nxt   = r_wptr == LAST_P ? '0 : r_wptr + ONE_P;
    assign w_rptr_nxt   = r_rptr == LAST_P ? '0 : r_rptr + ONE_P;
    assign m_data       = w_rdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= w_wptr_nxt;
            if (w_pop) r_rptr <= w_rptr_nxt;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

`ifdef RIV_SYNC_FIFO_PARITY_EN
    logic r_parity_err;

    assign w_wdata    = {^s_data, s_data};
    assign parity_err = r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_parity_err <= 1'b0;
        else     r_parity_err <= w_pop & ~flush & (^w_rdata);
    end
`else
    assign w_wdata = s_data;
`endif

    riv_sync_fifo_ram #(
        .W     (MEM_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_wen   (w_push & ~flush),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_riv_sync_fifo.sv
// tb_riv_sync_fifo: table-driven corner cases plus randomized traffic against a queue model.
module tb_riv_sync_fifo;
    localparam int DW = 16;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [2:0]    count;
    logic          almost_full, almost_empty;
`ifdef RIV_SYNC_FIFO_PARITY_EN
    logic          parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] q[$];

    riv_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef RIV_SYNC_FIFO_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            fl, sv;
        logic [DW-1:0] d;
        bit            mr;
        int            cnt;
        bit            mv, sr, af, ae;
        logic [DW-1:0] md;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // drive one cycle and advance the queue model by the handshake rules
    task automatic step(input bit fl, input bit sv, input logic [DW-1:0] d, input bit mr);
        bit pu, po;
        pu = sv && q.size() < D;
        po = mr && q.size() > 0;
        flush = fl; s_valid = sv; s_data = d; m_ready = mr;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(d);
        end
        #1;
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " count"}, 32'(count), 32'(q.size()));
        chk({tag, " m_valid"}, 32'(m_valid), 32'(q.size() > 0));
        chk({tag, " s_ready"}, 32'(s_ready), 32'(q.size() < D));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
        if (q.size() > 0) chk({tag, " m_data"}, 32'(m_data), 32'(q[0]));
`ifdef RIV_SYNC_FIFO_PARITY_EN
        chk({tag, " parity_err"}, 32'(parity_err), 32'h0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 1, 16'h0, 0, 1, 1, 1, 0, 1, 16'h0};
        tbl[1]  = '{0, 1, 16'h1, 0, 2, 1, 1, 0, 0, 16'h0};
        tbl[2]  = '{0, 1, 16'h2, 0, 3, 1, 1, 0, 0, 16'h0};
        tbl[3]  = '{0, 1, 16'h3, 0, 4, 1, 1, 1, 0, 16'h0};
        tbl[4]  = '{0, 1, 16'h4, 0, 5, 1, 0, 1, 0, 16'h0};
        tbl[5]  = '{0, 1, 16'h5, 0, 5, 1, 0, 1, 0, 16'h0};
        tbl[6]  = '{0, 1, 16'h6, 0, 5, 1, 0, 1, 0, 16'h0};
        tbl[7]  = '{0, 1, 16'h7, 1, 4, 1, 1, 1, 0, 16'h1};
        tbl[8]  = '{0, 0, 16'h0, 1, 3, 1, 1, 0, 0, 16'h2};
        tbl[9]  = '{0, 1, 16'h8, 1, 3, 1, 1, 0, 0, 16'h3};
        tbl[10] = '{0, 0, 16'h0, 1, 2, 1, 1, 0, 0, 16'h4};
        tbl[11] = '{0, 0, 16'h0, 1, 1, 1, 1, 0, 1, 16'h8};
        tbl[12] = '{0, 0, 16'h0, 1, 0, 0, 1, 0, 1, 16'h0};
        tbl[13] = '{0, 0, 16'h0, 1, 0, 0, 1, 0, 1, 16'h0};
        tbl[14] = '{0, 1, 16'h9, 1, 1, 1, 1, 0, 1, 16'h9};
        tbl[15] = '{0, 1, 16'hA, 0, 2, 1, 1, 0, 0, 16'h9};
        tbl[16] = '{1, 1, 16'hB, 1, 0, 0, 1, 0, 1, 16'h0};
        tbl[17] = '{0, 1, 16'hC, 0, 1, 1, 1, 0, 1, 16'hC};

        #12;
        chk_model("reset");
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].sv, tbl[i].d, tbl[i].mr);
            chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("row%0d s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            chk($sformatf("row%0d almost_full", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("row%0d almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
            if (tbl[i].mv) chk($sformatf("row%0d m_data", i), 32'(m_data), 32'(tbl[i].md));
        end

        for (int i = 0; i < 3; i++) step(0, 1, DW'($urandom), 0);
        chk_model("prefill");
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk_model("async_rst");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 99) < 60, DW'($urandom),
                 $urandom_range(0, 99) < 50);
            chk_model($sformatf("rand%0d", i));
        end

`ifdef RIV_SYNC_FIFO_PARITY_EN
        step(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h5A00 + i), 0);
        dut.u_ram.r_mem[2][0] = ~dut.u_ram.r_mem[2][0];
        q[2][0] = ~q[2][0];
        step(0, 0, '0, 1);
        chk_model("par_pop0");
        step(0, 0, '0, 1);
        chk("par head flipped", 32'(m_data), 32'(16'h5A03));
        step(0, 0, '0, 1);
        chk("par pulse", 32'(parity_err), 32'h1);
        step(0, 0, '0, 0);
        chk("par pulse end", 32'(parity_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
